// File: rtl/uart_dma_sequencer.sv
// Bus-master sequencer: memory buffer -> UART TX FIFO, UART RX FIFO -> memory.
// Optional irq logic is built only when UART_DMA_IRQ_EN is defined.
module uart_dma_sequencer #(
    parameter int ADDR_W        = 16,
    parameter int LEN_W         = 12,
    parameter int TX_FIFO_DEPTH = 16
) (
    input  logic              system_clock,
    input  logic              reset,
    input  logic [1:0]        cfg_addr,
    input  logic              cfg_write,
    input  logic [31:0]       cfg_data_in,
    output logic [31:0]       cfg_data_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       uart_data_in,
    input  logic [31:0]       uart_data_out,
    output logic              uart_select_fifo,
    output logic              uart_select_config,
    output logic              uart_not_writing,
    input  logic              tx_slot_free,
    output logic              irq
);

    localparam int CW = $clog2(TX_FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        ARB, TX_FETCH, TX_PUSH, RX_POLL, RX_SAMPLE, RX_STORE, CFG
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tx_addr_q, tx_addr_d, rx_addr_q, rx_addr_d;
    logic [LEN_W-1:0]  tx_len_q, tx_len_d, rx_len_q, rx_len_d;
    logic              tx_busy_q, tx_busy_d, rx_busy_q, rx_busy_d;
    logic              tx_done_q, tx_done_d, rx_done_q, rx_done_d;
    logic              cfg_pend_q, cfg_pend_d;
    logic [1:0]        cfg_val_q, cfg_val_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic              last_rx_q, last_rx_d;
    logic [7:0]        byte_q, byte_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]       udata_q, udata_d;
    logic              sel_fifo_q, sel_fifo_d, sel_cfg_q, sel_cfg_d;
    logic              nw_q, nw_d;
    logic              tx_fin, rx_fin, tx_el, rx_el, push, irq_en_bit;

`ifdef UART_DMA_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;
    assign irq_en_bit = irq_en_q;
    assign irq        = irq_q;
`else
    assign irq_en_bit = 1'b0;
    assign irq        = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{cfg_data_in, uart_data_out};

    always_comb begin
        state_d     = state_q;
        tx_addr_d   = tx_addr_q;
        rx_addr_d   = rx_addr_q;
        tx_len_d    = tx_len_q;
        rx_len_d    = rx_len_q;
        tx_busy_d   = tx_busy_q;
        rx_busy_d   = rx_busy_q;
        tx_done_d   = tx_done_q;
        rx_done_d   = rx_done_q;
        cfg_pend_d  = cfg_pend_q;
        cfg_val_d   = cfg_val_q;
        credits_d   = credits_q;
        last_rx_d   = last_rx_q;
        byte_d      = byte_q;
        tx_fin      = 1'b0;
        rx_fin      = 1'b0;
`ifdef UART_DMA_IRQ_EN
        irq_en_d    = irq_en_q;
`endif
        tx_el = tx_busy_q && (credits_q != '0);
        rx_el = rx_busy_q;
        push  = (state_q == TX_PUSH);

        case (state_q)
            ARB: begin
                if (cfg_pend_q) begin
                    state_d = CFG;
                end else if (tx_el && (!rx_el || last_rx_q)) begin
                    state_d   = TX_FETCH;
                    last_rx_d = 1'b0;
                end else if (rx_el) begin
                    state_d   = RX_POLL;
                    last_rx_d = 1'b1;
                end
            end
            TX_FETCH: begin
                if (mem_ack) begin
                    byte_d  = mem_rdata;
                    state_d = TX_PUSH;
                end
            end
            TX_PUSH: begin
                tx_addr_d = tx_addr_q + ADDR_W'(1);
                tx_len_d  = tx_len_q - LEN_W'(1);
                if (tx_len_q == LEN_W'(1)) begin
                    tx_busy_d = 1'b0;
                    tx_fin    = 1'b1;
                end
                state_d = ARB;
            end
            RX_POLL: state_d = RX_SAMPLE;
            RX_SAMPLE: begin
                if (uart_data_out[8]) begin
                    state_d = ARB;
                end else begin
                    byte_d  = uart_data_out[7:0];
                    state_d = RX_STORE;
                end
            end
            RX_STORE: begin
                if (mem_ack) begin
                    rx_addr_d = rx_addr_q + ADDR_W'(1);
                    rx_len_d  = rx_len_q - LEN_W'(1);
                    if (rx_len_q == LEN_W'(1)) begin
                        rx_busy_d = 1'b0;
                        rx_fin    = 1'b1;
                    end
                    state_d = ARB;
                end
            end
            CFG: begin
                cfg_pend_d = 1'b0;
                state_d    = ARB;
            end
            default: state_d = ARB;
        endcase

        if (push && !tx_slot_free)
            credits_d = credits_q - CW'(1);
        else if (!push && tx_slot_free && credits_q != CW'(TX_FIFO_DEPTH))
            credits_d = credits_q + CW'(1);

        if (cfg_write) begin
            case (cfg_addr)
                2'd0: if (!tx_busy_q) tx_addr_d = cfg_data_in[ADDR_W-1:0];
                2'd1: if (!rx_busy_q) rx_addr_d = cfg_data_in[ADDR_W-1:0];
                2'd2: begin
                    if (!tx_busy_q) tx_len_d = cfg_data_in[LEN_W-1:0];
                    if (!rx_busy_q) rx_len_d = cfg_data_in[16 +: LEN_W];
                end
                default: begin
`ifdef UART_DMA_IRQ_EN
                    irq_en_d = cfg_data_in[2];
`endif
                    cfg_val_d = cfg_data_in[10:9];
                    if (cfg_data_in[8]) cfg_pend_d = 1'b1;
                    if (cfg_data_in[3]) tx_done_d = 1'b0;
                    if (cfg_data_in[4]) rx_done_d = 1'b0;
                    if (cfg_data_in[0] && !tx_busy_q) begin
                        credits_d = CW'(TX_FIFO_DEPTH);
                        if (tx_len_q == '0) tx_fin = 1'b1;
                        else tx_busy_d = 1'b1;
                    end
                    if (cfg_data_in[1] && !rx_busy_q) begin
                        if (rx_len_q == '0) rx_fin = 1'b1;
                        else rx_busy_d = 1'b1;
                    end
                end
            endcase
        end

        // Completion is applied last so it beats a same-cycle W1C.
        if (tx_fin) tx_done_d = 1'b1;
        if (rx_fin) rx_done_d = 1'b1;

`ifdef UART_DMA_IRQ_EN
        irq_d = irq_en_d && (tx_done_d || rx_done_d);
`endif

        mem_req_d   = (state_d == TX_FETCH) || (state_d == RX_STORE);
        mem_we_d    = (state_d == RX_STORE);
        mem_addr_d  = (state_d == TX_FETCH) ? tx_addr_d :
                      (state_d == RX_STORE) ? rx_addr_d : '0;
        mem_wdata_d = (state_d == RX_STORE) ? byte_d : 8'h00;
        sel_fifo_d  = (state_d == TX_PUSH) || (state_d == RX_POLL);
        sel_cfg_d   = (state_d == CFG);
        nw_d        = !((state_d == TX_PUSH) || (state_d == CFG));
        udata_d     = (state_d == TX_PUSH) ? 32'(byte_d) :
                      (state_d == CFG)     ? 32'(cfg_val_d) : 32'h0;
    end

    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB;
            tx_addr_q   <= '0;
            rx_addr_q   <= '0;
            tx_len_q    <= '0;
            rx_len_q    <= '0;
            tx_busy_q   <= 1'b0;
            rx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_done_q   <= 1'b0;
            cfg_pend_q  <= 1'b0;
            cfg_val_q   <= 2'b00;
            credits_q   <= CW'(TX_FIFO_DEPTH);
            last_rx_q   <= 1'b0;
            byte_q      <= 8'h00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            udata_q     <= 32'h0;
            sel_fifo_q  <= 1'b0;
            sel_cfg_q   <= 1'b0;
            nw_q        <= 1'b1;
`ifdef UART_DMA_IRQ_EN
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tx_addr_q   <= tx_addr_d;
            rx_addr_q   <= rx_addr_d;
            tx_len_q    <= tx_len_d;
            rx_len_q    <= rx_len_d;
            tx_busy_q   <= tx_busy_d;
            rx_busy_q   <= rx_busy_d;
            tx_done_q   <= tx_done_d;
            rx_done_q   <= rx_done_d;
            cfg_pend_q  <= cfg_pend_d;
            cfg_val_q   <= cfg_val_d;
            credits_q   <= credits_d;
            last_rx_q   <= last_rx_d;
            byte_q      <= byte_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            udata_q     <= udata_d;
            sel_fifo_q  <= sel_fifo_d;
            sel_cfg_q   <= sel_cfg_d;
            nw_q        <= nw_d;
`ifdef UART_DMA_IRQ_EN
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
`endif
        end
    end

    assign mem_req            = mem_req_q;
    assign mem_we             = mem_we_q;
    assign mem_addr           = mem_addr_q;
    assign mem_wdata          = mem_wdata_q;
    assign uart_data_in       = udata_q;
    assign uart_select_fifo   = sel_fifo_q;
    assign uart_select_config = sel_cfg_q;
    assign uart_not_writing   = nw_q;

    always_comb begin
        case (cfg_addr)
            2'd0: cfg_data_out = 32'(tx_addr_q);
            2'd1: cfg_data_out = 32'(rx_addr_q);
            2'd2: cfg_data_out = 32'(tx_len_q) | (32'(rx_len_q) << 16);
            default: cfg_data_out = {21'b0, cfg_val_q, cfg_pend_q, 3'b0,
                                     rx_done_q, tx_done_q, irq_en_bit,
                                     rx_busy_q, tx_busy_q};
        endcase
    end

endmodule

// File: doc/uart_dma_sequencer.md
Name: uart_dma_sequencer

Overview:
- Bus-master sequencer for the minimal UART's register interface: copies a memory buffer into the UART TX FIFO and drains the RX FIFO into a second buffer, without CPU involvement per byte.
- Sits between the CPU config bus, a byte-wide memory port and the UART's select_fifo/select_config/not_writing interface.
- It is the only driver of that interface.
- Arbitrates the single UART port between the TX channel, the RX channel and pending UART config writes.

Parameters:
- ADDR_W, 16, memory byte-address width.
- LEN_W, 12, transfer length counter width (≤16).
- TX_FIFO_DEPTH, 16, UART TX FIFO capacity; initial credit count.

Ports:
- system_clock  input  1  clock.
- reset  input  1  asynchronous, active-low.
- cfg_addr  input  2  register select: 0 TX_ADDR, 1 RX_ADDR, 2 LEN, 3 CTRL.
- cfg_write  input  1  one-cycle register write strobe.
- cfg_data_in  input  32  register write data.
- cfg_data_out  output  32  combinational read of the register at cfg_addr.
- mem_req  output  1  memory request, held until mem_ack.
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_W  byte address.
- mem_wdata  output  8  write data.
- mem_rdata  input  8  read data, valid with mem_ack.
- mem_ack  input  1  one-cycle completion.
- uart_data_in  output  32  to UART data_in.
- uart_data_out  input  32  from UART data_out; registered by the UART, valid one cycle after a read select.
- uart_select_fifo  output  1  UART FIFO select.
- uart_select_config  output  1  UART config select.
- uart_not_writing  output  1  0 = write.
- tx_slot_free  input  1  one pulse per byte the UART TX FIFO consumes.
- irq  output  1  level interrupt.

Behaviour:
- Reset values (asynchronous): all outputs 0 except uart_not_writing=1; all registers 0; credits = TX_FIFO_DEPTH; FSM in ARB.
- Registers:
  - TX_ADDR[ADDR_W-1:0] and RX_ADDR[ADDR_W-1:0] hold the running pointers.
  - LEN holds tx_len in [LEN_W-1:0] and rx_len in [16+LEN_W-1:16], both counting down.
  - CTRL write: bit0 tx_go, bit1 rx_go, bit2 irq_en, bit3 tx_done clear (W1C), bit4 rx_done clear (W1C), bit8 cfg_pending set, bits[10:9] uart cfg value {enable_tx, enable_rx}.
  - CTRL read: bit0 tx_busy, bit1 rx_busy, bit2 irq_en, bit3 tx_done, bit4 rx_done, bit8 cfg_pending, bits[10:9] cfg value.
- Writes to a busy channel's pointer or length field are ignored. A go bit on a busy channel is ignored.
- A go with length 0 sets that channel's done flag next cycle and issues no accesses.
- FSM states: ARB, TX_FETCH, TX_PUSH, RX_POLL, RX_SAMPLE, RX_STORE, CFG.
- ARB priority: cfg_pending first. Otherwise TX and RX are round-robin: the last-served channel loses ties.
  - TX is eligible only when tx_busy and credits>0.
  - RX is eligible when rx_busy.
  - With nothing eligible, the FSM stays in ARB.
- TX_FETCH: mem_req=1, mem_we=0, mem_addr=TX_ADDR. On mem_ack, latch mem_rdata and go to TX_PUSH.
- TX_PUSH: one cycle with uart_select_fifo=1, uart_not_writing=0, uart_data_in={24'b0, byte}. In the same cycle:
  - TX_ADDR+1, wrapping modulo 2^ADDR_W.
  - tx_len-1 and credit-1.
  - If tx_len reaches 0: clear tx_busy, set tx_done.
  - Next state ARB.
- RX_POLL: one cycle with uart_select_fifo=1, uart_not_writing=1; then RX_SAMPLE.
- RX_SAMPLE: if uart_data_out[8]=1 (empty, sign of the 9-bit FIFO word), return to ARB with no change. Otherwise latch [7:0] and go to RX_STORE.
- RX_STORE: mem_req=1, mem_we=1, mem_addr=RX_ADDR. On mem_ack: RX_ADDR+1 (wraps), rx_len-1; at 0 clear rx_busy and set rx_done; then ARB.
- CFG: one cycle with uart_select_config=1, uart_not_writing=0, uart_data_in={30'b0, cfg value}. Clears cfg_pending; then ARB.
- Credits:
  - tx_slot_free in the same cycle as a push leaves credits unchanged.
  - Increment saturates at TX_FIFO_DEPTH.
  - tx_go reloads credits to TX_FIFO_DEPTH only when the TX channel is idle.
- UART port: outputs other than in TX_PUSH/RX_POLL/CFG are selects=0, uart_not_writing=1, data 0. At most one select is active per cycle.
- A CTRL write coincident with channel completion: the completion's done-set wins over a W1C of the same bit.
- Reset mid-transfer: immediate abort, mem_req drops asynchronously, all counts cleared.

Optional Feature:
- UART_DMA_IRQ_EN defined: irq = irq_en & (tx_done | rx_done), cleared by the W1C bits.
- UART_DMA_IRQ_EN undefined: irq tied 0, CTRL bit2 is write-ignored and reads 0, no irq logic is synthesised.

Test Plan:
- TX_ADDR=0x0100, tx_len=3, tx_go, mem returns 0x41,0x42,0x43 with 2-cycle ack -> three TX_PUSH writes of 0x41,0x42,0x43 in order; TX_ADDR=0x0103; tx_done=1; irq=1 if irq_en.
- TX_FIFO_DEPTH=2, tx_len=5, no tx_slot_free -> exactly 2 pushes then stall in ARB; each later tx_slot_free pulse allows exactly one more push.
- rx_len=2, UART returns empty (bit8=1) twice, then 0x55, then 0xAA -> memory writes 0x55@RX_ADDR, 0xAA@RX_ADDR+1 only; rx_done=1.
- TX and RX both busy with credits available -> service alternates TX,RX,TX,RX; a cfg_pending write (bits[10:9]=2'b11) preempts at the next ARB with one config write of 0x3.
- tx_go with tx_len=0 -> tx_done next cycle, mem_req never asserted; TX_ADDR=0xFFFF, tx_len=2 -> fetches from 0xFFFF then 0x0000.
- Assert reset during TX_FETCH with mem_req=1 -> mem_req=0 immediately; all registers 0; credits=TX_FIFO_DEPTH after release.
